// File: rtl/mm_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : mm_seg_display
//  Description : Four-digit multiplexed 7-segment driver for BCD values.
//                A strobed BCD word is held pending and is moved into the
//                display register only at the end of a full scan frame. This
//                keeps the digits of one frame consistent with each other.
//                The digit outputs are registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    REFRESH_DIV   clk cycles each digit stays selected (2 .. 2^20)
//    DP_POS        digit index (0..3) whose decimal point is lit
//  Ports
//    clk           system clock
//    rst_n         asynchronous active-low reset
//    clr_i         synchronous clear of displayed and pending data
//    din_bcd_i     4-digit BCD value, [3:0] = units digit
//    din_update_i  single-cycle strobe qualifying din_bcd_i
//    an_o          digit enables, active-low, an_o[n] selects digit n
//    seg_o         segments {g,f,e,d,c,b,a}, active-low
//    dp_o          decimal point, active-low
//    frame_o       one-cycle pulse on every commit cycle
//  Build option
//    MM_DISP_LZB_EN  when defined, enables leading-zero blanking for digits
//                    above DP_POS
// ============================================================================
module mm_seg_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int DP_POS      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic [15:0] din_bcd_i,
    input  logic        din_update_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int                 c_DIV_W  = $clog2(REFRESH_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_TC = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [1:0]         c_DP_IDX = 2'(DP_POS);

    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_idx;
    logic [15:0]        r_disp;
    logic [15:0]        r_pend;
    logic               r_pend_vld;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_tc;
    logic               w_commit;
    logic [3:0]         w_nib;
    logic [6:0]         w_dec;
    logic               w_blank;
    logic [3:0]         w_an;
    logic [6:0]         w_seg;
    logic               w_dp;

    assign w_tc     = (r_div == c_DIV_TC);
    assign w_commit = w_tc && (r_idx == 2'd3);

    // Nibble select for the digit that is currently scanned
    always_comb begin
        w_nib = r_disp[3:0];
        case (r_idx)
            2'd0:    w_nib = r_disp[3:0];
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            default: w_nib = r_disp[15:12];
        endcase
    end

    // Active-low BCD decode. Values that are not BCD show a dash.
    always_comb begin
        w_dec = 7'h3F;
        case (w_nib)
            4'd0:    w_dec = 7'h40;
            4'd1:    w_dec = 7'h79;
            4'd2:    w_dec = 7'h24;
            4'd3:    w_dec = 7'h30;
            4'd4:    w_dec = 7'h19;
            4'd5:    w_dec = 7'h12;
            4'd6:    w_dec = 7'h02;
            4'd7:    w_dec = 7'h78;
            4'd8:    w_dec = 7'h00;
            4'd9:    w_dec = 7'h10;
            default: w_dec = 7'h3F;
        endcase
    end

`ifdef MM_DISP_LZB_EN
    // w_lz[n] is set when digit n and every higher digit are zero
    logic [3:0] w_lz;
    always_comb begin
        w_lz[3] = (r_disp[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'd0);
        w_lz[0] = w_lz[1] && (r_disp[3:0] == 4'd0);
    end
    assign w_blank = (r_idx > c_DP_IDX) && w_lz[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_an        = 4'hF;
        w_an[r_idx] = 1'b0;
        w_seg       = w_dec;
        if (w_blank) begin
            w_an  = 4'hF;
            w_seg = 7'h7F;
        end
        w_dp = (r_idx == c_DP_IDX) ? 1'b0 : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_idx      <= 2'd0;
            r_disp     <= 16'h0000;
            r_pend     <= 16'h0000;
            r_pend_vld <= 1'b0;
            r_an       <= 4'hF;
            r_seg      <= 7'h7F;
            r_dp       <= 1'b1;
        end else if (clr_i) begin
            // Clear wins over a coincident strobe, which is dropped
            r_div      <= '0;
            r_idx      <= 2'd0;
            r_disp     <= 16'h0000;
            r_pend     <= 16'h0000;
            r_pend_vld <= 1'b0;
            r_an       <= 4'hF;
            r_seg      <= 7'h7F;
            r_dp       <= 1'b1;
        end else begin
            if (w_tc) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end

            if (w_commit && r_pend_vld) begin
                r_disp <= r_pend;
            end

            // A strobe on the commit cycle refills pending after the old
            // value has been committed, so it shows on the following frame.
            if (din_update_i) begin
                r_pend     <= din_bcd_i;
                r_pend_vld <= 1'b1;
            end else if (w_commit) begin
                r_pend_vld <= 1'b0;
            end

            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign frame_o = w_commit;

endmodule
`default_nettype wire

// File: tb/tb_mm_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_seg_display
//  Description : Self-checking bench for mm_seg_display (REFRESH_DIV=4,
//                DP_POS=2). Expected digit outputs are queued when a value is
//                strobed and compared as each digit of the frame appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_seg_display;

    logic        clk;
    logic        rst_n;
    logic        clr_i;
    logic [15:0] din_bcd_i;
    logic        din_update_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    mm_seg_display #(
        .REFRESH_DIV (4),
        .DP_POS      (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_i),
        .din_bcd_i    (din_bcd_i),
        .din_update_i (din_update_i),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .frame_o      (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     val;
        logic [3:0][6:0] segs;   // {digit3, digit2, digit1, digit0}
        logic            lz3;    // digit 3 is a leading zero
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t tbl [9];
    exp_t q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if ({an_o, seg_o, dp_o} !== e) begin
            n_err++;
            $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     name, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
        end
    endtask

    task automatic check_frame_low(input string name);
        n_vec++;
        if (frame_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got frame_o=%b, expected 0", name, frame_o);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.an    = 4'hF;
            e.an[d] = 1'b0;
            e.seg   = v.segs[d];
            e.dp    = (d == 2) ? 1'b0 : 1'b1;
`ifdef MM_DISP_LZB_EN
            if (d == 3 && v.lz3) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end
`endif
            q.push_back(e);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        din_bcd_i    = v;
        din_update_i = 1'b1;
        @(posedge clk);
        #1;
        din_update_i = 1'b0;
    endtask

    // Returns on the negedge where frame_o is seen high
    task automatic wait_frame(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: frame_o never pulsed within 40 cycles", name);
        end
    endtask

    // Called just after the commit edge; compares the four digits of a frame
    task automatic observe_digits(input string name);
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 1 : 4) @(posedge clk);
            #1;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: scoreboard empty at digit %0d", name, d);
            end else begin
                check(name, q.pop_front());
            end
        end
    endtask

    task automatic observe_frame(input string name);
        bit ok;
        wait_frame(name, ok);
        if (ok) begin
            @(posedge clk);
            observe_digits(name);
        end else begin
            q.delete();
        end
    endtask

    initial begin
        exp_t off;
        int   cnt;
        bit   ok;

        tbl[0] = '{val: 16'h0330, segs: {7'h40, 7'h30, 7'h30, 7'h40}, lz3: 1'b1};
        tbl[1] = '{val: 16'h00A5, segs: {7'h40, 7'h40, 7'h3F, 7'h12}, lz3: 1'b1};
        tbl[2] = '{val: 16'h1234, segs: {7'h79, 7'h24, 7'h30, 7'h19}, lz3: 1'b0};
        tbl[3] = '{val: 16'h9876, segs: {7'h10, 7'h00, 7'h78, 7'h02}, lz3: 1'b0};
        tbl[4] = '{val: 16'hF00C, segs: {7'h3F, 7'h40, 7'h40, 7'h3F}, lz3: 1'b0};
        tbl[5] = '{val: 16'h0045, segs: {7'h40, 7'h40, 7'h19, 7'h12}, lz3: 1'b1};
        tbl[6] = '{val: 16'h0100, segs: {7'h40, 7'h79, 7'h40, 7'h40}, lz3: 1'b1};
        tbl[7] = '{val: 16'h0200, segs: {7'h40, 7'h24, 7'h40, 7'h40}, lz3: 1'b1};
        tbl[8] = '{val: 16'h0000, segs: {7'h40, 7'h40, 7'h40, 7'h40}, lz3: 1'b1};
        off    = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

        rst_n        = 1'b0;
        clr_i        = 1'b0;
        din_bcd_i    = 16'h0000;
        din_update_i = 1'b0;

        // Reset state
        #12;
        check("reset_outputs", off);
        check_frame_low("reset_frame");
        @(negedge clk);
        rst_n = 1'b1;

        // Main table: decode, decimal point, invalid nibbles
        for (int i = 0; i < 5; i++) begin
            strobe(tbl[i].val);
            push_exp(tbl[i]);
            observe_frame($sformatf("table_%04h", tbl[i].val));
        end

        // Two strobes inside one frame: only the later one is shown
        strobe(16'h0123);
        strobe(16'h0045);
        push_exp(tbl[5]);
        observe_frame("overwrite");

        // Strobe on the commit cycle while 0x0100 is pending
        strobe(16'h0100);
        wait_frame("coincident_wait", ok);
        if (ok) begin
            din_bcd_i    = 16'h0200;
            din_update_i = 1'b1;
            @(posedge clk);
            #1;
            din_update_i = 1'b0;
            push_exp(tbl[6]);
            observe_digits("coincident_n1");
            push_exp(tbl[7]);
            observe_frame("coincident_n2");
        end

        // Frame pulse rate: exactly two pulses in any 32-cycle window
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_o === 1'b1) cnt++;
        end
        n_vec++;
        if (cnt != 2) begin
            n_err++;
            $display("FAIL frame_rate: got %0d pulses in 32 cycles, expected 2", cnt);
        end

        // Clear during digit 2 with a simultaneous strobe
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (an_o === 4'b1011) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL clear_wait: digit 2 never selected, an=%h", an_o);
        end else begin
            clr_i        = 1'b1;
            din_bcd_i    = 16'h5555;
            din_update_i = 1'b1;
            @(posedge clk);
            #1;
            clr_i        = 1'b0;
            din_update_i = 1'b0;
            check("clear_blank", off);
            push_exp(tbl[8]);
            observe_digits("clear_restart");
            push_exp(tbl[8]);
            observe_frame("clear_strobe_lost");
        end

        // Reset mid-scan discards an uncommitted pending value
        strobe(16'h7777);
        rst_n = 1'b0;
        #1;
        check("reset_mid_scan", off);
        check_frame_low("reset_mid_frame");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_exp(tbl[8]);
        observe_digits("reset_restart");
        push_exp(tbl[8]);
        observe_frame("reset_pending_lost");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_seg_display.md
MM_SEG_DISPLAY -- requirements
Module: mm_seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles each digit stays selected (legal 2..2^20).
REQ-002 SHALL have parameter DP_POS, default 2, meaning the digit index (0..3) whose decimal point is lit, so 330 reads 3.30.
REQ-003 SHALL have clk  input  1  system clock.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have clr_i  input  1  synchronous clear of displayed and pending data.
REQ-006 SHALL have din_bcd_i  input  16  4-digit BCD value, with [3:0] as the units digit.
REQ-007 SHALL have din_update_i  input  1  single-cycle strobe qualifying din_bcd_i.
REQ-008 SHALL have an_o  output  4  digit enables, active-low, where an_o[n] selects digit n.
REQ-009 SHALL have seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have dp_o  output  1  decimal point, active-low.
REQ-011 SHALL have frame_o  output  1  one-cycle pulse on every commit cycle.

Function
REQ-012 SHALL capture din_bcd_i into a pending register and set pending_valid on the clk edge where din_update_i=1; a later strobe overwrites the earlier one.
REQ-013 SHALL run a divider counting 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-014 The commit cycle SHALL be the terminal count with index=3; on it frame_o=1, and if pending_valid the display register loads pending and pending_valid clears.
REQ-015 SHALL handle din_update_i on a commit cycle by committing the old pending value and loading the new value into pending with pending_valid left at 1, so the new value shows next frame.
REQ-016 SHALL register an_o, seg_o and dp_o, changing them one cycle after the index change, and no display register change SHALL be visible before the next commit.
REQ-017 an_o SHALL drive only bit [index] low.
REQ-018 seg_o SHALL decode the selected nibble as 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-019 seg_o SHALL decode nibbles 10..15 as 0x3F (dash, segment g only).
REQ-020 dp_o SHALL be 0 only while index=DP_POS, and 1 otherwise.
REQ-021 clr_i=1 SHALL, on the next edge, clear the display register, pending register, pending_valid, divider and index, and set an_o=0xF, seg_o=0x7F and dp_o=1.
REQ-022 clr_i SHALL take priority over a simultaneous din_update_i, which is dropped.
REQ-023 After clr_i deasserts, scanning SHALL restart at index 0 showing value 0x0000.

Reset
REQ-024 While rst_n=0, the block SHALL immediately hold an_o=0xF, seg_o=0x7F, dp_o=1, frame_o=0, divider=0, index=0, display=0, pending=0 and pending_valid=0.
REQ-025 Reset asserted mid-frame SHALL discard any uncommitted pending value.
REQ-026 The first scan edge SHALL occur on the first clk edge after rst_n rises, with index 0 displayed one cycle later.

Configuration
REQ-027 Macro MM_DISP_LZB_EN defined SHALL enable leading-zero blanking.
REQ-028 With MM_DISP_LZB_EN defined, a digit with index greater than DP_POS SHALL be blanked (an_o bit high, seg_o=0x7F) when it and every higher digit are 0.
REQ-029 With MM_DISP_LZB_EN defined, digits with index at or below DP_POS SHALL never be blanked.
REQ-030 With MM_DISP_LZB_EN undefined, all four digits SHALL always be driven, and no blanking logic is synthesized.

Verification (REFRESH_DIV=4, DP_POS=2)
REQ-031 SHALL cover reset: rst_n low mid-scan -> an_o=0xF, seg_o=0x7F, dp_o=1 immediately, and index 0 scan resumes after release.
REQ-032 SHALL cover display of 3.30: din_bcd_i=0x0330 pulsed, then wait one commit.
- Digit 0 -> seg 0x40.
- Digit 1 -> seg 0x30.
- Digit 2 -> seg 0x30 with dp_o=0.
- Digit 3 -> blanked with LZB enabled, seg 0x40 with LZB disabled.
REQ-033 SHALL cover overwrite: strobes 0x0123 then 0x0045 within one frame -> only 0x0045 is displayed after commit, with exactly one frame_o pulse per 16 cycles.
REQ-034 SHALL cover a coincident update: strobe 0x0200 on the commit cycle while pending holds 0x0100 -> frame N+1 shows 0100 and frame N+2 shows 0200.
REQ-035 SHALL cover an invalid nibble: din_bcd_i=0x00A5 -> digit 1 seg 0x3F and digit 0 seg 0x12.
REQ-036 SHALL cover clear: clr_i pulsed during index 2 with a simultaneous strobe -> an_o=0xF the next cycle, then restart at digit 0 showing 0000 with the strobe lost.
